// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and stall/flush controls back to it
interface pipeline_hazard_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              IDEX_MemRead_i;
    logic [ADDR_W-1:0] IDEX_RtAddr_i;
    logic [ADDR_W-1:0] IFID_RsAddr_i;
    logic [ADDR_W-1:0] IFID_RtAddr_i;
    logic              Branch_taken_i;
    logic              dmem_req_i;
    logic              dmem_ack_i;
    logic              PC_write_o;
    logic              IFID_write_o;
    logic              IDEX_bubble_o;
    logic              IFID_flush_o;
    logic              pipe_freeze_o;
    logic              timeout_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    modport master (
        output IDEX_MemRead_i, IDEX_RtAddr_i, IFID_RsAddr_i, IFID_RtAddr_i,
               Branch_taken_i, dmem_req_i, dmem_ack_i,
        input  PC_write_o, IFID_write_o, IDEX_bubble_o, IFID_flush_o,
               pipe_freeze_o, timeout_o, stall_cnt_o
    );
    modport slave (
        input  IDEX_MemRead_i, IDEX_RtAddr_i, IFID_RsAddr_i, IFID_RtAddr_i,
               Branch_taken_i, dmem_req_i, dmem_ack_i,
        output PC_write_o, IFID_write_o, IDEX_bubble_o, IFID_flush_o,
               pipe_freeze_o, timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use bubble, branch flush, memory freeze and timeout halt sequencer
module pipeline_hazard_ctrl #(
    parameter int ADDR_W       = 5,
    parameter int CNT_W        = 16,
    parameter int MAX_MEM_WAIT = 15
) (
    input logic clk_i,
    input logic rst_i,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WW = $clog2(MAX_MEM_WAIT + 1);
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_e;
    state_e            state_q, state_d;
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              mem_busy, lu, freeze, bubble, stall;
    always_comb begin
        mem_busy = hz.dmem_req_i & ~hz.dmem_ack_i;
        lu = hz.IDEX_MemRead_i & (hz.IDEX_RtAddr_i != ADDR_W'(0)) &
             ((hz.IDEX_RtAddr_i == hz.IFID_RsAddr_i) | (hz.IDEX_RtAddr_i == hz.IFID_RtAddr_i));
        freeze = ~rst_i & ((state_q == HALT) | mem_busy);
        bubble = ~rst_i & ~freeze & lu;
        stall = freeze | bubble;
        hz.pipe_freeze_o = freeze;
        hz.IDEX_bubble_o = bubble;
        hz.PC_write_o = ~stall;
        hz.IFID_write_o = ~stall;
        hz.IFID_flush_o = ~rst_i & ~freeze & ~lu & hz.Branch_taken_i;
        hz.timeout_o = timeout_q;
        hz.stall_cnt_o = stall_cnt_q;
        state_d = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d = timeout_q;
        stall_cnt_d = stall_cnt_q + CNT_W'(stall & ~&stall_cnt_q);
        if (state_q == RUN && mem_busy) begin
            state_d = MEM_WAIT;
            wait_cnt_d = WW'(1);
        end else if (state_q == MEM_WAIT) begin
            // a dropped request is handled exactly like an ack
            if (!mem_busy) begin
                state_d = RUN;
                wait_cnt_d = '0;
            end else if (wait_cnt_q == WW'(MAX_MEM_WAIT)) begin
                state_d = HALT;
                timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + WW'(1);
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            wait_cnt_q <= '0;
            timeout_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
